// File: rtl/mul_div_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Holds the op encoding, the control FSM state type and the iteration-count helper.
// No logic of its own.
package mul_div_pkg;

  // op[1] selects divide, op[0] selects signed operands
  localparam logic [1:0] OP_MULU = 2'b00;
  localparam logic [1:0] OP_MULS = 2'b01;
  localparam logic [1:0] OP_DIVU = 2'b10;
  localparam logic [1:0] OP_DIVS = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Number of CALC cycles needed to walk every bit of the A operand
  function automatic int calc_iter(input int width_a, input int bits_per_cycle);
    return width_a / bits_per_cycle;
  endfunction

endpackage

// File: rtl/mul_div_step.sv
// One radix-2 iteration: MSB-first shift-add (mul) or restoring shift-subtract (div).
// Latency: combinational. Backpressure: none, it is chained inside the owner's CALC state.
// Ports: is_div selects the operation; b_mag is the multiplier/divisor magnitude;
//   acc_in/acc_out carry the partial product (mul) or partial remainder in the low
//   WIDTH_B bits (div); sh_in/sh_out carry the A operand bits still to consume,
//   with quotient bits shifted in from the bottom during divide.
module mul_div_step #(
  parameter int WIDTH_A = 128,
  parameter int WIDTH_B = 64
) (
  input  logic                       is_div,
  input  logic [WIDTH_B-1:0]         b_mag,
  input  logic [WIDTH_A+WIDTH_B-1:0] acc_in,
  input  logic [WIDTH_A-1:0]         sh_in,
  output logic [WIDTH_A+WIDTH_B-1:0] acc_out,
  output logic [WIDTH_A-1:0]         sh_out
);

  localparam int WR = WIDTH_A + WIDTH_B;

  logic [WIDTH_B:0]   trial;
  logic               fits;
  logic [WIDTH_B-1:0] rem_next;

  always_comb begin
    // Remainder is always < divisor, so 2*rem+bit needs just one extra bit
    trial    = {acc_in[WIDTH_B-1:0], sh_in[WIDTH_A-1]};
    fits     = (trial >= {1'b0, b_mag});
    // When the subtraction is skipped trial < divisor, so it fits WIDTH_B bits
    rem_next = WIDTH_B'(fits ? (trial - {1'b0, b_mag}) : trial);
    if (is_div) begin
      acc_out = {{WIDTH_A{1'b0}}, rem_next};
      sh_out  = {sh_in[WIDTH_A-2:0], fits};
    end else begin
      acc_out = (acc_in << 1) + (sh_in[WIDTH_A-1] ? {{WIDTH_A{1'b0}}, b_mag} : {WR{1'b0}});
      sh_out  = {sh_in[WIDTH_A-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative signed/unsigned multiply and divide with remainder and div-zero/overflow flags.
// Latency: out_valid ITER+1 cycles after accept (ITER = WIDTH_A/BITS_PER_CYCLE); one op per ITER+3.
// Backpressure: holds result in DONE while out_ready=0; in_ready only in IDLE, no bypass.
// Ports: in_valid/in_ready/op/a/b operand handshake; out_valid/out_ready/result/div_zero/ovf
//   result handshake. Divide result packs {remainder, quotient}.
// Optional: define MUL_DIV_ZERO_SKIP_EN to jump IDLE->DONE when an operand makes the answer trivial.
module mul_div_unit
  import mul_div_pkg::*;
#(
  parameter int WIDTH_A        = 128,
  parameter int WIDTH_B        = 64,
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0]                 op,
  input  logic [WIDTH_A-1:0]         a,
  input  logic [WIDTH_B-1:0]         b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH_A+WIDTH_B-1:0] result,
  output logic                       div_zero,
  output logic                       ovf
);

  localparam int ITER = calc_iter(WIDTH_A, BITS_PER_CYCLE);
  localparam int CW   = $clog2(ITER + 1);
  localparam int WR   = WIDTH_A + WIDTH_B;
  localparam logic [CW-1:0]      LAST     = CW'(ITER - 1);
  localparam logic [WIDTH_A-1:0] MOST_NEG = {1'b1, {(WIDTH_A-1){1'b0}}};

  state_t state, state_nxt;

  logic               is_div;
  logic               a_neg, b_neg;
  logic [WIDTH_B-1:0] b_mag;
  logic [WIDTH_B-1:0] a_lo;
  logic [WR-1:0]      acc;
  logic [WIDTH_A-1:0] shreg;
  logic [CW-1:0]      cnt;

  // Operand magnitudes; only signed ops can have a negative operand
  logic               a_neg_in, b_neg_in;
  logic [WIDTH_A-1:0] a_mag_in;
  logic [WIDTH_B-1:0] b_mag_in;
  logic               skip;

  assign a_neg_in = op[0] & a[WIDTH_A-1];
  assign b_neg_in = op[0] & b[WIDTH_B-1];
  assign a_mag_in = a_neg_in ? -a : a;
  assign b_mag_in = b_neg_in ? -b : b;

`ifdef MUL_DIV_ZERO_SKIP_EN
  logic [WR-1:0] skip_result;
  assign skip        = (a == '0) || (b == '0);
  assign skip_result = (op[1] && (b == '0)) ? {a[WIDTH_B-1:0], {WIDTH_A{1'b1}}} : {WR{1'b0}};
`else
  assign skip = 1'b0;
`endif

  // Step chain: BITS_PER_CYCLE radix-2 iterations per CALC cycle
  logic [WR-1:0]      acc_chain [BITS_PER_CYCLE+1];
  logic [WIDTH_A-1:0] sh_chain  [BITS_PER_CYCLE+1];

  assign acc_chain[0] = acc;
  assign sh_chain[0]  = shreg;

  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
    mul_div_step #(
      .WIDTH_A (WIDTH_A),
      .WIDTH_B (WIDTH_B)
    ) u_step (
      .is_div  (is_div),
      .b_mag   (b_mag),
      .acc_in  (acc_chain[i]),
      .sh_in   (sh_chain[i]),
      .acc_out (acc_chain[i+1]),
      .sh_out  (sh_chain[i+1])
    );
  end

  // Sign correction: quotient truncates toward zero, remainder follows the dividend
  logic [WIDTH_A-1:0] quo;
  logic [WIDTH_B-1:0] rem;
  logic [WR-1:0]      fix_result;

  always_comb begin
    quo = (a_neg ^ b_neg) ? -shreg : shreg;
    rem = a_neg ? -acc[WIDTH_B-1:0] : acc[WIDTH_B-1:0];
    if (!is_div)
      fix_result = (a_neg ^ b_neg) ? -acc : acc;
    else if (div_zero)
      fix_result = {a_lo, {WIDTH_A{1'b1}}};
    else
      fix_result = {rem, quo};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = skip ? DONE : CALC;
      end
      CALC: if (cnt == LAST) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      is_div   <= 1'b0;
      a_neg    <= 1'b0;
      b_neg    <= 1'b0;
      b_mag    <= '0;
      a_lo     <= '0;
      acc      <= '0;
      shreg    <= '0;
      cnt      <= '0;
      result   <= '0;
      div_zero <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          is_div   <= op[1];
          a_neg    <= a_neg_in;
          b_neg    <= b_neg_in;
          b_mag    <= b_mag_in;
          a_lo     <= a[WIDTH_B-1:0];
          acc      <= '0;
          shreg    <= a_mag_in;
          cnt      <= '0;
          div_zero <= op[1] && (b == '0);
          ovf      <= (op == OP_DIVS) && (a == MOST_NEG) && (b == '1);
`ifdef MUL_DIV_ZERO_SKIP_EN
          if (skip) result <= skip_result;
`endif
        end
        CALC: begin
          acc   <= acc_chain[BITS_PER_CYCLE];
          shreg <= sh_chain[BITS_PER_CYCLE];
          cnt   <= cnt + CW'(1);
        end
        FIX: result <= fix_result;
        default: ;
      endcase
    end
  end

endmodule
